// File: rtl/dndata.sv
// Serial frame receiver: rebuilds two MSB-first bytes from a ready-framed bit stream
// and hands them to the consumer over a valid/ack handshake with framing and overrun flags.
module dndata (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_RDY8,
    input  logic       DATA_in8,
    input  logic       ack_in,
    output logic       out_RDY8,
    output logic [7:0] DATA_out1,
    output logic [7:0] DATA_out2,
    output logic       frm_err,
    output logic       ovr_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] sh_q, sh_d;
    logic [7:0]  d1_q, d1_d;
    logic [7:0]  d2_q, d2_d;
    logic        rdy_q, rdy_d;
    logic        frm_q, frm_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        rdy_d   = rdy_q & ~ack_in;
        frm_d   = 1'b0;
        ovr_d   = ovr_q & ~ack_in;

        case (state_q)
            IDLE: begin
                // The lead cycle carries no data bit.
                if (in_RDY8) begin
                    cnt_d   = 4'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (in_RDY8) begin
                    sh_d  = {sh_q[14:0], DATA_in8};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        // Completion overrides a same-edge ack; overrun only if the old frame is still unacked.
                        d1_d    = sh_q[14:7];
                        d2_d    = {sh_q[6:0], DATA_in8};
                        rdy_d   = 1'b1;
                        if (rdy_q && !ack_in) begin
                            ovr_d = 1'b1;
                        end
                        state_d = WAIT_LOW;
                    end
                end else begin
                    frm_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!in_RDY8) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 16'd0;
            d1_q    <= 8'd0;
            d2_q    <= 8'd0;
            rdy_q   <= 1'b0;
            frm_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            rdy_q   <= rdy_d;
            frm_q   <= frm_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_RDY8  = rdy_q;
    assign DATA_out1 = d1_q;
    assign DATA_out2 = d2_q;
    assign frm_err   = frm_q;
    assign ovr_err   = ovr_q;

endmodule

// File: tb/tb_dndata.sv
// Scoreboard bench for dndata: stimulus queues expected frames, a negedge monitor
// pops and compares each time the receiver presents a new frame.
module tb_dndata;

    logic       clk;
    logic       rst;
    logic       in_RDY8;
    logic       DATA_in8;
    logic       ack_in;
    logic       out_RDY8;
    logic [7:0] DATA_out1;
    logic [7:0] DATA_out2;
    logic       frm_err;
    logic       ovr_err;

    dndata dut (
        .clk      (clk),
        .rst      (rst),
        .in_RDY8  (in_RDY8),
        .DATA_in8 (DATA_in8),
        .ack_in   (ack_in),
        .out_RDY8 (out_RDY8),
        .DATA_out1(DATA_out1),
        .DATA_out2(DATA_out2),
        .frm_err  (frm_err),
        .ovr_err  (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frm_cnt = 0;

    logic [16:0] exp_q[$];   // {byte1, byte2, ovr_err}
    logic        prev_rdy;
    logic [15:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a frame is presented when valid rises or the data changes while valid.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            prev_rdy  = 1'b0;
            prev_data = 16'h0;
        end else begin
            if (frm_err) frm_cnt++;
            if (out_RDY8 && (!prev_rdy || {DATA_out1, DATA_out2} != prev_data)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got 0x%0h%0h expected none at %0t",
                             DATA_out1, DATA_out2, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_byte1", {24'h0, DATA_out1}, {24'h0, e[16:9]});
                    chk("frame_byte2", {24'h0, DATA_out2}, {24'h0, e[8:1]});
                    chk("frame_ovr", {31'h0, ovr_err}, {31'h0, e[0]});
                end
            end
            prev_rdy  = out_RDY8;
            prev_data = {DATA_out1, DATA_out2};
        end
    end

    // Drive one cycle's inputs, then advance to just after the next rising edge.
    task automatic drive_bit(input logic r, input logic d);
        in_RDY8  = r;
        DATA_in8 = d;
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [15:0] w, input logic ack_last, input int extra_high);
        drive_bit(1'b1, 1'b0);
        for (int i = 15; i >= 0; i--) begin
            if (i == 0) ack_in = ack_last;
            drive_bit(1'b1, w[i]);
        end
        ack_in = 1'b0;
        for (int i = 0; i < extra_high; i++) drive_bit(1'b1, i[0]);
        drive_bit(1'b0, 1'b0);
    endtask

    task automatic do_ack();
        ack_in = 1'b1;
        drive_bit(1'b0, 1'b0);
        ack_in = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        rst = 1'b1; in_RDY8 = 1'b0; DATA_in8 = 1'b0; ack_in = 1'b0;
        #3;
        chk("reset_rdy", {31'h0, out_RDY8}, 32'h0);
        chk("reset_data", {16'h0, DATA_out1, DATA_out2}, 32'h0);
        chk("reset_errs", {30'h0, frm_err, ovr_err}, 32'h0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #2;

        // Nominal frame and ack.
        exp_q.push_back({8'hA5, 8'h3C, 1'b0});
        send_frame(16'hA53C, 1'b0, 0);
        chk("nominal_rdy", {31'h0, out_RDY8}, 32'h1);
        do_ack();
        chk("nominal_ack_clears", {31'h0, out_RDY8}, 32'h0);

        // Truncated after 9 bits: one frm_err pulse, previous data held.
        f0 = frm_cnt;
        drive_bit(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) drive_bit(1'b1, i[0]);
        drive_bit(1'b0, 1'b0);
        chk("trunc_pulse_high", {31'h0, frm_err}, 32'h1);
        drive_bit(1'b0, 1'b0);
        chk("trunc_pulse_low", {31'h0, frm_err}, 32'h0);
        drive_bit(1'b0, 1'b0);
        chk("trunc_pulse_count", frm_cnt - f0, 32'd1);
        chk("trunc_data_held", {16'h0, DATA_out1, DATA_out2}, 32'hA53C);
        chk("trunc_rdy", {31'h0, out_RDY8}, 32'h0);
        exp_q.push_back({8'hFF, 8'h00, 1'b0});
        send_frame(16'hFF00, 1'b0, 0);
        do_ack();

        // Overrun.
        exp_q.push_back({8'h12, 8'h34, 1'b0});
        send_frame(16'h1234, 1'b0, 0);
        exp_q.push_back({8'h56, 8'h78, 1'b1});
        send_frame(16'h5678, 1'b0, 0);
        chk("ovr_set", {31'h0, ovr_err}, 32'h1);
        do_ack();
        chk("ovr_cleared", {31'h0, ovr_err}, 32'h0);
        chk("ovr_rdy_cleared", {31'h0, out_RDY8}, 32'h0);

        // Ack on the completion edge while valid: completion wins, no overrun.
        exp_q.push_back({8'h11, 8'h22, 1'b0});
        send_frame(16'h1122, 1'b0, 0);
        exp_q.push_back({8'h0F, 8'hF0, 1'b0});
        send_frame(16'h0FF0, 1'b1, 0);
        chk("simul_rdy", {31'h0, out_RDY8}, 32'h1);
        chk("simul_ovr", {31'h0, ovr_err}, 32'h0);
        chk("simul_data", {16'h0, DATA_out1, DATA_out2}, 32'h0FF0);
        do_ack();

        // Ready stuck high for 40 cycles: exactly one frame, no retrigger.
        f0 = frm_cnt;
        exp_q.push_back({8'hC3, 8'h5A, 1'b0});
        send_frame(16'hC35A, 1'b0, 23);
        drive_bit(1'b0, 1'b0);
        chk("stuck_no_frm", frm_cnt - f0, 32'd0);
        chk("stuck_data", {16'h0, DATA_out1, DATA_out2}, 32'hC35A);
        do_ack();

        // Async reset between edges after 5 bits.
        f0 = frm_cnt;
        drive_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b1);
        #1;
        rst = 1'b1; in_RDY8 = 1'b0;
        #1;
        chk("arst_data", {16'h0, DATA_out1, DATA_out2}, 32'h0);
        chk("arst_flags", {29'h0, out_RDY8, frm_err, ovr_err}, 32'h0);
        @(posedge clk); #4;
        rst = 1'b0;
        @(posedge clk); #2;
        drive_bit(1'b0, 1'b0);
        chk("arst_no_frm", frm_cnt - f0, 32'd0);
        exp_q.push_back({8'h81, 8'h7E, 1'b0});
        send_frame(16'h817E, 1'b0, 0);
        do_ack();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
